hidden_cpu_core: RTL and testbench
==================================

# hidden_cpu_core

Parametrised successor to the TinyTapeout 8-bit hidden CPU: a four-register accumulator-style core with a configurable data width, program-counter width and scratch-RAM depth. Instructions arrive on a valid/ready port, and the core reports `pc` for external fetch. A two-state controller gives loads a registered-RAM wait cycle. The output mux (r3 or pc) and the carry-conditional relative branch carry over from the previous generation. PC advance, branch priority and RAM access are now well defined.

## Interface
- `DATA_W`, 8, register, ALU and RAM word width (≥4)
- `PC_W`, 8, program-counter width; pc wraps mod 2^PC_W
- `RAM_AW`, 3, scratch-RAM address width; depth 2^RAM_AW
- `clk` input 1: the single clock; all state updates on posedge
- `rst` input 1: asynchronous, active-low reset
- `instr` input 8: instruction `[7:6]` op, `[5:4]` ra, `[3:2]` rb, `[1:0]` fn
- `instr_valid` input 1: `instr` is presented
- `instr_ready` output 1: core accepts `instr` this cycle
- `pc` output PC_W: address of the next instruction to fetch
- `dout` output DATA_W: `sel_out ? pc` (zero-extended or truncated) `: r3`
- `carry` output 1: carry/borrow flag

## Operation
- Reset (rst=0, asynchronous) sets: r0=0, r1=1, r2=2, r3=3, pc=0, carry=0, sel_out=0, state=EXEC. RAM is not reset. Resulting outputs: `dout`=3, `instr_ready`=1.
- An instruction is accepted when `instr_valid & instr_ready`. Each accepted instruction advances pc by 1, unless it is a taken branch or a jump.
- Operands: all reads use pre-edge register values.
- op=00 ALU, result to ra:
  - fn00 ADD ra+rb; carry←carry-out.
  - fn01 SUB ra−rb (mod 2^DATA_W); carry←borrow.
  - fn10 AND; fn11 XOR; carry unchanged for both.
- op=01 MEM. The RAM address is the low RAM_AW bits of a register.
  - fn00 ST: ram[ra]←rb.
  - fn01 LD: ra←ram[rb]; goes to LOAD_WAIT.
  - fn10 MOV: ra←rb.
  - fn11 NOT: ra←~rb.
- op=10 IMM: ra←zero-extended {rb,fn} (4-bit immediate, 0..15).
- op=11 CTRL:
  - fn00 BCS: if carry, pc←pc+rb (rb truncated or zero-extended to PC_W, mod 2^PC_W); else pc+1.
  - fn01 JMP: pc←rb (truncated or zero-extended).
  - fn10 TOG: sel_out←~sel_out.
  - fn11 CLC: carry←0.
- State machine:
  - EXEC (`instr_ready`=1): on accepting LD, latch the RAM read address, pc+1, go to LOAD_WAIT. Every other instruction completes in EXEC.
  - LOAD_WAIT (`instr_ready`=0): ra←registered RAM data; return to EXEC. `instr_valid` is ignored here.
- Boundaries:
  - ST with ra==rb index stores that register's value.
  - ST followed directly by LD of the same address returns the stored value.
  - pc wraps from 2^PC_W−1 to 0.
  - A branch offset wraps modulo 2^PC_W, so it can move pc backwards.
  - Reset during LOAD_WAIT aborts the load; ra keeps its reset value.
  - When `instr_valid`=0 in EXEC, no state changes.

## Timing
- Non-LD instructions: one cycle. The register, carry, pc and sel_out updates are visible on the posedge that accepts the instruction.
- LD: the destination register updates on the 2nd posedge after acceptance. `instr_ready` is low for exactly one cycle.
- `pc`, `dout`, `carry` and `instr_ready` are registered or a direct decode of registered state. There is no combinational path from `instr` to any output.
- Throughput: one instruction per cycle, except a LD, which takes two.

## Test plan
All scenarios use the default parameters.
- **Reset:** release rst → `dout`=0x03, `pc`=0, `carry`=0, `instr_ready`=1. Assert rst mid-run → all values return to reset immediately, without a clock edge.
- **ADD/SUB flags:** ADD r3,r3 → `dout`=0x06, `carry`=0. SUB r0,r1 → r0=0xFF, `carry`=1. MOV r3,r0 → `dout`=0xFF.
- **Branch:** with `carry`=1 and r3=3, BCS rb=r3 at pc=2 → `pc`=5. After CLC, the same BCS → `pc`=+1. JMP with r2=0xFF, then any ALU op → `pc`=0x00 (wrap).
- **Memory:** IMM r3=0xA, ST ram[r2]←r3, LD r0←ram[r2] → `instr_ready` low one cycle; r0=0x0A two edges after LD acceptance. An `instr_valid` pulse during LOAD_WAIT is not executed.
- **Output mux:** TOG → `dout` follows `pc`. Second TOG → `dout`=r3.
- **Reset mid-load:** accept LD, assert rst in LOAD_WAIT → `instr_ready`=1, destination register equals its reset value, `pc`=0.

Source files
------------

// File: rtl/hidden_cpu_core_if.sv
// Instruction/status bundle between the hidden CPU core and its fetch/host side.
interface hidden_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic [7:0]        instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] dout;
  logic              carry;

  modport master (output instr, output instr_valid,
                  input instr_ready, input pc, input dout, input carry);
  modport slave  (input instr, input instr_valid,
                  output instr_ready, output pc, output dout, output carry);
endinterface

// File: rtl/hidden_cpu_core.sv
// Four-register accumulator core: 1-cycle ALU/MEM/IMM/CTRL ops, 2-cycle loads
// through a registered scratch RAM. pc is exported for external fetch.
module hidden_cpu_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int RAM_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  hidden_cpu_core_if.slave  bus
);
  typedef enum logic {EXEC, LOAD_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_regs [4];
  logic [PC_W-1:0]   r_pc;
  logic              r_carry, r_sel;
  logic [1:0]        r_ld_ra;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_ram [2**RAM_AW];

  logic [1:0]        w_op, w_ra, w_rb, w_fn;
  logic [DATA_W-1:0] w_a, w_b;
  logic [DATA_W:0]   w_sum, w_diff;
  logic              w_wr_en, w_st_en, w_ld_go, w_carry_nxt, w_sel_nxt;
  logic [1:0]        w_wr_idx;
  logic [DATA_W-1:0] w_wr_data;
  logic [PC_W-1:0]   w_pc_nxt;

  assign w_op   = bus.instr[7:6];
  assign w_ra   = bus.instr[5:4];
  assign w_rb   = bus.instr[3:2];
  assign w_fn   = bus.instr[1:0];
  assign w_a    = r_regs[w_ra];
  assign w_b    = r_regs[w_rb];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_ra;
    w_wr_data   = w_a;
    w_carry_nxt = r_carry;
    w_sel_nxt   = r_sel;
    w_pc_nxt    = r_pc;
    w_st_en     = 1'b0;
    w_ld_go     = 1'b0;
    case (r_state)
      EXEC: if (bus.instr_valid) begin
        w_pc_nxt = r_pc + PC_W'(1);
        case (w_op)
          2'b00: begin
            w_wr_en = 1'b1;
            case (w_fn)
              2'b00: begin w_wr_data = w_sum[DATA_W-1:0];  w_carry_nxt = w_sum[DATA_W];  end
              2'b01: begin w_wr_data = w_diff[DATA_W-1:0]; w_carry_nxt = w_diff[DATA_W]; end
              2'b10: w_wr_data = w_a & w_b;
              default: w_wr_data = w_a ^ w_b;
            endcase
          end
          2'b01: begin
            case (w_fn)
              2'b00: w_st_en = 1'b1;
              2'b01: begin w_ld_go = 1'b1; w_state_nxt = LOAD_WAIT; end
              2'b10: begin w_wr_en = 1'b1; w_wr_data = w_b;  end
              default: begin w_wr_en = 1'b1; w_wr_data = ~w_b; end
            endcase
          end
          2'b10: begin
            w_wr_en   = 1'b1;
            w_wr_data = DATA_W'(bus.instr[3:0]);
          end
          default: begin
            case (w_fn)
              2'b00: if (r_carry) w_pc_nxt = r_pc + PC_W'(w_b);
              2'b01: w_pc_nxt = PC_W'(w_b);
              2'b10: w_sel_nxt = ~r_sel;
              default: w_carry_nxt = 1'b0;
            endcase
          end
        endcase
      end
      default: begin
        // LOAD_WAIT: retire the load from the registered RAM word; instr_valid ignored
        w_wr_en     = 1'b1;
        w_wr_idx    = r_ld_ra;
        w_wr_data   = r_ram_q;
        w_state_nxt = EXEC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EXEC;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= DATA_W'(i);
      r_pc    <= '0;
      r_carry <= 1'b0;
      r_sel   <= 1'b0;
      r_ld_ra <= '0;
    end else begin
      if (w_wr_en) r_regs[w_wr_idx] <= w_wr_data;
      if (w_ld_go) r_ld_ra <= w_ra;
      r_pc    <= w_pc_nxt;
      r_carry <= w_carry_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Scratch RAM holds its contents across reset; read is registered at LD accept
  always_ff @(posedge clk) begin
    if (w_st_en) r_ram[w_a[RAM_AW-1:0]] <= w_b;
    if (w_ld_go) r_ram_q <= r_ram[w_b[RAM_AW-1:0]];
  end

  assign bus.instr_ready = (r_state == EXEC);
  assign bus.pc          = r_pc;
  assign bus.dout        = r_sel ? DATA_W'(r_pc) : r_regs[3];
  assign bus.carry       = r_carry;
endmodule

// File: tb/tb_hidden_cpu_core.sv
// Directed test-plan steps followed by a random instruction stream, all
// checked against an arithmetic reference model of the ISA.
module tb_hidden_cpu_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int   m_regs [4];
  int   m_ram  [8];
  int   m_pc;
  bit   m_carry, m_sel;

  hidden_cpu_core_if #(.DATA_W(8), .PC_W(8)) bus ();
  hidden_cpu_core #(.DATA_W(8), .PC_W(8), .RAM_AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = i;
    m_pc = 0; m_carry = 0; m_sel = 0;
  endtask

  task automatic model_exec(input logic [7:0] ins, output bit is_ld, output int ld_ra, output int ld_val);
    int op, ra, rb, fn, a, b, npc;
    op = ins[7:6]; ra = ins[5:4]; rb = ins[3:2]; fn = ins[1:0];
    a = m_regs[ra]; b = m_regs[rb];
    npc = (m_pc + 1) % 256;
    is_ld = 0; ld_ra = ra; ld_val = 0;
    case (op)
      0: case (fn)
        0: begin m_regs[ra] = (a + b) % 256; m_carry = (a + b) > 255; end
        1: begin m_carry = a < b; m_regs[ra] = (a - b + 256) % 256; end
        2: m_regs[ra] = a & b;
        default: m_regs[ra] = a ^ b;
      endcase
      1: case (fn)
        0: m_ram[a % 8] = b;
        1: begin is_ld = 1; ld_val = m_ram[b % 8]; end
        2: m_regs[ra] = b;
        default: m_regs[ra] = 255 - b;
      endcase
      2: m_regs[ra] = int'(ins[3:0]);
      default: case (fn)
        0: if (m_carry) npc = (m_pc + b) % 256;
        1: npc = b;
        2: m_sel = !m_sel;
        default: m_carry = 0;
      endcase
    endcase
    m_pc = npc;
  endtask

  task automatic check_all(input string tag, input bit exp_ready);
    chk({tag, ".pc"},    bus.pc,          m_pc);
    chk({tag, ".dout"},  bus.dout,        m_sel ? m_pc : m_regs[3]);
    chk({tag, ".carry"}, bus.carry,       m_carry);
    chk({tag, ".ready"}, bus.instr_ready, exp_ready);
  endtask

  // One issue slot; a LD also spends its wait cycle here, optionally with a stray valid pulse
  task automatic step(input string tag, input logic [7:0] ins, input bit vld, input bit pulse);
    bit is_ld; int ld_ra, ld_val;
    @(negedge clk);
    bus.instr = ins; bus.instr_valid = vld;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    if (vld) begin
      model_exec(ins, is_ld, ld_ra, ld_val);
      if (is_ld) begin
        check_all({tag, ".wait"}, 1'b0);
        if (pulse) begin
          @(negedge clk);
          bus.instr = 8'($urandom); bus.instr_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        m_regs[ld_ra] = ld_val;
      end
    end
    check_all(tag, 1'b1);
  endtask

  task automatic reset_cycle();
    @(negedge clk); rst = 1'b0; model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.instr = 8'h00; bus.instr_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    check_all("reset", 1'b1);
    chk("reset.dout3", bus.dout, 8'h03);

    // ALU and flags
    step("add_r3r3", 8'h3C, 1, 0); chk("add.dout", bus.dout, 8'h06); chk("add.carry", bus.carry, 1'b0);
    step("sub_r0r1", 8'h05, 1, 0); chk("sub.carry", bus.carry, 1'b1);
    step("mov_r3r0", 8'h72, 1, 0); chk("mov.dout", bus.dout, 8'hFF);
    step("idle", 8'h3C, 0, 0);

    // Branches and pc wrap
    reset_cycle();
    step("sub_set_c", 8'h05, 1, 0);
    step("and_nop",   8'h16, 1, 0);
    step("bcs_taken", 8'hCC, 1, 0); chk("bcs_taken.pc", bus.pc, 8'd5);
    step("clc",       8'hC3, 1, 0);
    step("bcs_not",   8'hCC, 1, 0); chk("bcs_not.pc", bus.pc, 8'd7);
    step("mov_r2r0",  8'h62, 1, 0);
    step("jmp_r2",    8'hC9, 1, 0); chk("jmp.pc", bus.pc, 8'hFF);
    step("wrap",      8'h16, 1, 0); chk("wrap.pc", bus.pc, 8'h00);

    // Memory: store then immediate load of the same address, stray valid in LOAD_WAIT
    step("imm_r3_a",  8'hBA, 1, 0);
    step("st_r2_r3",  8'h6C, 1, 0);
    step("ld_r0_r2",  8'h49, 1, 1);
    step("mov_r3r0b", 8'h72, 1, 0); chk("ld.dout", bus.dout, 8'h0A);

    // Output mux
    step("tog1", 8'hC2, 1, 0); chk("tog1.dout", bus.dout, bus.pc);
    step("tog2", 8'hC2, 1, 0); chk("tog2.dout", bus.dout, 8'h0A);

    // Reset during LOAD_WAIT: r3 must keep its reset value
    @(negedge clk);
    bus.instr = 8'h79; bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk("rstld.wait_ready", bus.instr_ready, 1'b0);
    #2 rst = 1'b0; model_reset();
    #1;
    check_all("rstld", 1'b1);
    chk("rstld.dout3", bus.dout, 8'h03);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_all("rstld.after", 1'b1);

    // Random phase: fill RAM with known data first
    for (int i = 0; i < 8; i++) begin
      step("fill_a", {4'b1000, 4'(i)}, 1, 0);
      step("fill_d", {4'b1001, 4'(15 - i)}, 1, 0);
      step("fill_st", 8'h44, 1, 0);
    end
    for (int n = 0; n < 400; n++) begin
      step("rand", 8'($urandom), ($urandom % 4) != 0, 1'($urandom));
      if (n % 97 == 96) reset_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
